mem_arbiter: RTL and testbench

- Sits directly downstream of the per-thread load/store units.
- Arbitrates NUM_CONSUMERS valid/ready read and write requests onto NUM_CHANNELS external memory channels.
- Relays read data or write completion back to the requesting consumer.
- One instance serves data memory; a read-only instance (WRITE_ENABLE=0) serves program memory.

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates per-consumer read/write requests onto NUM_CHANNELS memory channels and relays results.
// Define MEM_ARBITER_ROUND_ROBIN_EN for a rotating per-channel scan start; default is fixed priority.
module mem_arbiter #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int unsigned CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] StIdle          = 3'd0;
  localparam logic [2:0] StReadWaiting   = 3'd1;
  localparam logic [2:0] StWriteWaiting  = 3'd2;
  localparam logic [2:0] StReadRelaying  = 3'd3;
  localparam logic [2:0] StWriteRelaying = 3'd4;

  logic [2:0]    state_q [NUM_CHANNELS];
  logic [2:0]    state_d [NUM_CHANNELS];
  logic [CW-1:0] cur_q   [NUM_CHANNELS];
  logic [CW-1:0] cur_d   [NUM_CHANNELS];
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic [CW-1:0] ptr_q   [NUM_CHANNELS];
  logic [CW-1:0] ptr_d   [NUM_CHANNELS];
`endif

  logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d, taken;
  logic [NUM_CONSUMERS-1:0] read_ready_d, write_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_d;
  logic [NUM_CHANNELS-1:0]  mrv_d, mwv_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mra_d, mwa_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mwd_d;
  logic [CW-1:0] idx;
  logic          found;

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    ptr_d         = ptr_q;
`endif
    claimed_d     = claimed_q;
    // Claims made this cycle are visible to higher channels; releases only from next cycle.
    taken         = claimed_q;
    read_ready_d  = consumer_read_ready;
    write_ready_d = consumer_write_ready;
    read_data_d   = consumer_read_data;
    mrv_d         = mem_read_valid;
    mra_d         = mem_read_address;
    mwv_d         = mem_write_valid;
    mwa_d         = mem_write_address;
    mwd_d         = mem_write_data;
    idx           = '0;
    found         = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        StIdle: begin
          found = 1'b0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            idx = CW'((int'(ptr_q[ch]) + k) % NUM_CONSUMERS);
`else
            idx = CW'(k);
`endif
            if (!found && !taken[idx] && (consumer_read_valid[idx] ||
                (WRITE_ENABLE != 0 && consumer_write_valid[idx]))) begin
              found          = 1'b1;
              taken[idx]     = 1'b1;
              claimed_d[idx] = 1'b1;
              cur_d[ch]      = idx;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
              ptr_d[ch]      = CW'((int'(idx) + 1) % NUM_CONSUMERS);
`endif
              if (consumer_read_valid[idx]) begin
                mrv_d[ch] = 1'b1;
                mra_d[ch*ADDR_BITS +: ADDR_BITS] =
                    consumer_read_address[idx*ADDR_BITS +: ADDR_BITS];
                state_d[ch] = StReadWaiting;
              end else begin
                mwv_d[ch] = 1'b1;
                mwa_d[ch*ADDR_BITS +: ADDR_BITS] =
                    consumer_write_address[idx*ADDR_BITS +: ADDR_BITS];
                mwd_d[ch*DATA_BITS +: DATA_BITS] =
                    consumer_write_data[idx*DATA_BITS +: DATA_BITS];
                state_d[ch] = StWriteWaiting;
              end
            end
          end
        end
        StReadWaiting: begin
          if (mem_read_ready[ch]) begin
            mrv_d[ch] = 1'b0;
            read_data_d[cur_q[ch]*DATA_BITS +: DATA_BITS] =
                mem_read_data[ch*DATA_BITS +: DATA_BITS];
            read_ready_d[cur_q[ch]] = 1'b1;
            state_d[ch] = StReadRelaying;
          end
        end
        StWriteWaiting: begin
          if (mem_write_ready[ch]) begin
            mwv_d[ch] = 1'b0;
            write_ready_d[cur_q[ch]] = 1'b1;
            state_d[ch] = StWriteRelaying;
          end
        end
        StReadRelaying: begin
          if (!consumer_read_valid[cur_q[ch]]) begin
            read_ready_d[cur_q[ch]] = 1'b0;
            claimed_d[cur_q[ch]]    = 1'b0;
            state_d[ch]             = StIdle;
          end
        end
        StWriteRelaying: begin
          if (!consumer_write_valid[cur_q[ch]]) begin
            write_ready_d[cur_q[ch]] = 1'b0;
            claimed_d[cur_q[ch]]     = 1'b0;
            state_d[ch]              = StIdle;
          end
        end
        default: state_d[ch] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= StIdle;
        cur_q[ch]   <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        ptr_q[ch]   <= '0;
`endif
      end
      claimed_q            <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      state_q              <= state_d;
      cur_q                <= cur_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      ptr_q                <= ptr_d;
`endif
      claimed_q            <= claimed_d;
      consumer_read_ready  <= read_ready_d;
      consumer_read_data   <= read_data_d;
      consumer_write_ready <= write_ready_d;
      mem_read_valid       <= mrv_d;
      mem_read_address     <= mra_d;
      mem_write_valid      <= mwv_d;
      mem_write_address    <= mwa_d;
      mem_write_data       <= mwd_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-channel read/write instance against a behavioural memory model,
// and a 1-channel read-only instance for priority, round-robin and write-tie-off behaviour.
module tb_mem_arbiter;
  localparam int NC  = 4;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main instance: 2 channels, writes enabled.
  logic [NC-1:0]    rv = '0, wv = '0, rr, wr;
  logic [NC*8-1:0]  ra = '0, wa = '0, wd = '0, rd;
  logic [NCH-1:0]   mrv, mwv, mrr = '0, mwr = '0;
  logic [NCH*8-1:0] mra, mwa, mwd, mrd = '0;

  // Read-only instance: 1 channel; write requests held high to show they are ignored.
  logic [NC-1:0]    ro_rv = '0, ro_rr, ro_wr;
  logic [NC-1:0]    ro_wv = '1;
  logic [NC*8-1:0]  ro_ra = '0, ro_rd;
  logic [NC*8-1:0]  ro_wa = '1, ro_wd = '1;
  logic [0:0]       ro_mrv, ro_mwv, ro_mrr = '0;
  logic [0:0]       ro_mwr = 1'b1;
  logic [7:0]       ro_mra, ro_mwa, ro_mwd, ro_mrd = '0;

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH),
                .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(rr), .consumer_read_data(rd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(wr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1),
                .WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .reset(reset),
    .consumer_read_valid(ro_rv), .consumer_read_address(ro_ra),
    .consumer_read_ready(ro_rr), .consumer_read_data(ro_rd),
    .consumer_write_valid(ro_wv), .consumer_write_address(ro_wa),
    .consumer_write_data(ro_wd), .consumer_write_ready(ro_wr),
    .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
    .mem_read_ready(ro_mrr), .mem_read_data(ro_mrd),
    .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa),
    .mem_write_data(ro_mwd), .mem_write_ready(ro_mwr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // External memory seen by the main instance, and the expected contents from consumer writes.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  int cnt [NCH];
  int lat [NCH];
  int fixed_lat = 0;
  int mem_txns  = 0;
  int dup_cnt   = 0;
  bit dup_en    = 1'b0;

  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (reset) begin
        cnt[ch] = 0; mrr[ch] = 1'b0; mwr[ch] = 1'b0;
      end else if (mrr[ch] || mwr[ch]) begin
        mrr[ch] = 1'b0; mwr[ch] = 1'b0;
      end else if (mrv[ch] || mwv[ch]) begin
        if (cnt[ch] == 0) begin
          lat[ch] = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
          mem_txns++;
        end
        cnt[ch]++;
        if (cnt[ch] >= lat[ch]) begin
          cnt[ch] = 0;
          if (mrv[ch]) begin
            mrd[ch*8 +: 8] = mem[mra[ch*8 +: 8]];
            mrr[ch] = 1'b1;
          end else begin
            mem[mwa[ch*8 +: 8]] = mwd[ch*8 +: 8];
            mwr[ch] = 1'b1;
          end
        end
      end
    end
  end

  // Addresses carry the consumer id in bits [7:6]; two active channels must never share one.
  function automatic logic [1:0] chan_id(input int ch);
    return mwv[ch] ? mwa[ch*8+6 +: 2] : mra[ch*8+6 +: 2];
  endfunction

  always @(negedge clk) begin
    if (dup_en && !reset && (mrv[0] || mwv[0]) && (mrv[1] || mwv[1]))
      if (chan_id(0) == chan_id(1)) dup_cnt++;
  end

  // Read-only memory: answers in one cycle with address ^ 0xC3; logs the granted consumer id.
  logic [1:0] grants [$];
  bit ro_write_seen = 1'b0;

  always @(negedge clk) begin
    if (reset) ro_mrr = 1'b0;
    else if (ro_mrr) ro_mrr = 1'b0;
    else if (ro_mrv[0]) begin
      ro_mrr = 1'b1;
      ro_mrd = ro_mra ^ 8'hC3;
      grants.push_back(ro_mra[7:6]);
    end
    if (ro_mwv != 0 || ro_mwa != 0 || ro_mwd != 0 || ro_wr != 0) ro_write_seen = 1'b1;
  end

  task automatic do_reset();
    reset = 1'b1; rv = '0; wv = '0; ro_rv = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One consumer transaction on the main instance; called and returns at a falling edge.
  task automatic cons_txn(input int c, input bit is_wr, input logic [7:0] addr,
                          input logic [7:0] data, output int n);
    if (is_wr) begin
      wa[c*8 +: 8] = addr; wd[c*8 +: 8] = data; wv[c] = 1'b1;
    end else begin
      ra[c*8 +: 8] = addr; rv[c] = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(is_wr ? wr[c] : rr[c]) && n < 200);
    check_eq($sformatf("c%0d_%s_ready", c, is_wr ? "wr" : "rd"), is_wr ? wr[c] : rr[c], 1);
    if (is_wr) begin
      ref_mem[addr] = data;
      wv[c] = 1'b0;
    end else begin
      check_eq($sformatf("c%0d_rd_data_%0h", c, addr), rd[c*8 +: 8], ref_mem[addr]);
      rv[c] = 1'b0;
    end
    @(negedge clk);
    check_eq($sformatf("c%0d_%s_ready_drop", c, is_wr ? "wr" : "rd"),
             is_wr ? wr[c] : rr[c], 0);
  endtask

  task automatic rand_consumer(input int c);
    int n;
    for (int t = 0; t < 15; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      cons_txn(c, 1'($urandom_range(0, 1)), {2'(c), 6'($urandom_range(0, 63))},
               8'($urandom), n);
    end
  endtask

  task automatic ro_repeat(input int c);
    int n;
    for (int k = 0; k < 4; k++) begin
      ro_ra[c*8 +: 8] = 8'(c * 64 + k);
      ro_rv[c] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ro_rr[c] && n < 200);
      check_eq($sformatf("rr_c%0d_data%0d", c, k), ro_rd[c*8 +: 8], 8'(c * 64 + k) ^ 8'hC3);
      ro_rv[c] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rem [2];
    int ptr;
    int pick;
    bit got;
    int exp_g [$];

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h12] = 8'hAB; ref_mem[8'h12] = 8'hAB;

    // Reset values while reset is held.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_rd_ready", rr, 0);
    check_eq("rst_wr_ready", wr, 0);
    check_eq("rst_rd_data", rd, 0);
    check_eq("rst_mem_valid", {mrv, mwv}, 0);
    check_eq("rst_mem_addr", {mra, mwa}, 0);
    check_eq("rst_mem_wdata", mwd, 0);
    check_eq("rst_ro_outputs", {ro_rr, ro_mrv, ro_mra}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read, memory latency 3: consumer ready one cycle after memory ready.
    fixed_lat = 3;
    fork
      cons_txn(0, 1'b0, 8'h12, 8'h00, n);
      begin
        @(negedge clk);
        check_eq("single_mrv", mrv, 2'b01);
        check_eq("single_mra", mra[7:0], 8'h12);
      end
    join
    check_eq("single_latency", n, 4);

    // Write path.
    fixed_lat = 2;
    fork
      cons_txn(1, 1'b1, 8'h03, 8'h5A, n);
      begin
        @(negedge clk);
        check_eq("wr_mwv", mwv, 2'b01);
        check_eq("wr_mwa", mwa[7:0], 8'h03);
        check_eq("wr_mwd", mwd[7:0], 8'h5A);
        check_eq("wr_no_read", mrv, 0);
      end
    join
    check_eq("wr_latency", n, 3);
    check_eq("wr_mem_written", mem[8'h03], 8'h5A);

    // All four consumers at once on two channels.
    dup_en = 1'b1;
    fork
      cons_txn(0, 1'b0, 8'h05, 8'h00, n);
      cons_txn(1, 1'b0, 8'h45, 8'h00, n);
      cons_txn(2, 1'b0, 8'h85, 8'h00, n);
      cons_txn(3, 1'b0, 8'hC5, 8'h00, n);
      begin
        @(negedge clk);
        check_eq("par_first_mrv", mrv, 2'b11);
        check_eq("par_first_mra", mra, 16'h4505);
        repeat (4) @(negedge clk);
        check_eq("par_second_mrv", mrv, 2'b11);
        check_eq("par_second_mra", mra, 16'hC585);
      end
    join
    dup_en = 1'b0;

    // Same consumer with read and write pending: read first, write in a later claim.
    fixed_lat = 1;
    ra[31:24] = 8'hC1; wa[31:24] = 8'hC2; wd[31:24] = 8'h77;
    rv[3] = 1'b1; wv[3] = 1'b1;
    @(negedge clk);
    check_eq("both_mrv", mrv, 2'b01);
    check_eq("both_mwv", mwv, 2'b00);
    n = 0;
    while (!rr[3] && n < 50) begin @(negedge clk); n++; end
    check_eq("both_rd_ready", rr[3], 1);
    check_eq("both_rd_data", rd[31:24], ref_mem[8'hC1]);
    check_eq("both_wr_pending", wr[3], 0);
    rv[3] = 1'b0;
    n = 0;
    while (!wr[3] && n < 50) begin @(negedge clk); n++; end
    check_eq("both_wr_ready", wr[3], 1);
    ref_mem[8'hC2] = 8'h77;
    check_eq("both_wr_mem", mem[8'hC2], 8'h77);
    wv[3] = 1'b0;
    @(negedge clk);
    check_eq("both_wr_drop", wr[3], 0);

    // Reset while a read waits on memory, then a normal read.
    fixed_lat = 20;
    ra[7:0] = 8'h10; rv[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; rv = '0;
    @(negedge clk);
    check_eq("midrst_valids", {mrv, mwv}, 0);
    check_eq("midrst_readies", {rr, wr}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_no_ready", rr, 0);
    fixed_lat = 2;
    cons_txn(0, 1'b0, 8'h10, 8'h00, n);
    check_eq("midrst_latency", n, 3);

    // Randomized traffic from all consumers with random memory latency.
    fixed_lat = 0;
    mem_txns = 0;
    dup_cnt = 0;
    dup_en = 1'b1;
    for (int c = 0; c < NC; c++) begin
      fork
        automatic int cc = c;
        rand_consumer(cc);
      join_none
    end
    wait fork;
    dup_en = 1'b0;
    check_eq("rand_no_dup_claim", dup_cnt, 0);
    check_eq("rand_mem_txns", mem_txns, 60);

    // Single channel contention: consumer 0 before consumer 2.
    do_reset();
    grants.delete();
    ro_ra[7:0] = 8'h01; ro_ra[23:16] = 8'h80; ro_rv = 4'b0101;
    n = 0;
    while (ro_rv != 0 && n < 60) begin
      @(negedge clk); n++;
      if (ro_rr[0] && ro_rv[0]) begin
        check_eq("cont_c0_data", ro_rd[7:0], 8'h01 ^ 8'hC3); ro_rv[0] = 1'b0;
      end
      if (ro_rr[2] && ro_rv[2]) begin
        check_eq("cont_c2_data", ro_rd[23:16], 8'h80 ^ 8'hC3); ro_rv[2] = 1'b0;
      end
    end
    ro_rv = '0;
    check_eq("cont_grants", grants.size(), 2);
    check_eq("cont_first", (grants.size() > 0) ? 32'(grants[0]) : 32'hF, 0);
    check_eq("cont_second", (grants.size() > 1) ? 32'(grants[1]) : 32'hF, 2);

    // Two consumers re-requesting continuously; grant order from the priority rule.
    do_reset();
    grants.delete();
    rem[0] = 4; rem[1] = 4; ptr = 0;
    for (int g = 0; g < 8; g++) begin
      got = 1'b0; pick = 0;
      for (int s = 0; s < NC; s++)
        if (!got && ((ptr + s) % NC) < 2 && rem[(ptr + s) % NC] > 0) begin
          got = 1'b1; pick = (ptr + s) % NC;
        end
      exp_g.push_back(pick);
      rem[pick]--;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      ptr = (pick + 1) % NC;
`endif
    end
    fork
      ro_repeat(0);
      ro_repeat(1);
    join
    check_eq("rr_grant_count", grants.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("rr_grant%0d", i),
               (i < grants.size()) ? 32'(grants[i]) : 32'hF, exp_g[i]);

    check_eq("ro_write_outputs_zero", ro_write_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
